// File: rtl/imem_pkg.sv
// Shared constants and stage payload type for the clocked instruction memory.
package imem_pkg;

  localparam logic [63:0] NOP_INSTR   = '0;
  localparam int          LATENCY_MIN = 1;
  localparam int          LATENCY_MAX = 4;

  // Payload for the default 32-bit instruction width; the top builds the DATA_W-wide equivalent.
  typedef struct packed {
    logic        valid;
    logic        fault;
    logic [31:0] instr;
  } imem_stage_t;

endpackage

// File: rtl/imem_pipe_stage.sv
// One read-pipeline register: holds on stall, drops its valid on flush, and only
// captures payload when the incoming slot is valid so the data outputs hold between fetches.
module imem_pipe_stage
  import imem_pkg::*;
#(
  parameter type payload_t = imem_stage_t
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_en,
  input  logic     i_clr,
  input  payload_t i_d,
  output payload_t o_q
);

  payload_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q.valid <= 1'b0;
    end else if (i_en) begin
      if (i_d.valid) begin
        r_q <= i_d;
      end else begin
        r_q.valid <= 1'b0;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Clocked instruction memory for the fetch stage: valid/ready request, pipelined read of
// LATENCY cycles with back-pressure, fault tagging, flush and a program-load write port.
module instr_fetch_mem
  import imem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 32,
  parameter int    DEPTH     = 1024,
  parameter int    BYTE_ADDR = 1,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_instr,
  output logic                     rsp_fault,
  input  logic                     flush,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]        prog_data
);

  localparam int IDX_W = $clog2(DEPTH);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX ||
      DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $fatal(1, "instr_fetch_mem: illegal LATENCY=%0d or DEPTH=%0d (image '%s')",
           LATENCY, DEPTH, INIT_FILE);
  end

  typedef struct packed {
    logic              valid;
    logic              fault;
    logic [DATA_W-1:0] instr;
  } stage_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  stage_t            r_rd;
  stage_t            w_stage [LATENCY];

  logic [ADDR_W-1:0] w_idx_full;
  logic [IDX_W-1:0]  w_idx;
  logic              w_misalign;
  logic              w_range;
  logic              w_fault;
  logic              w_stall;
  logic              w_accept;

  // Range test uses the untruncated index so large addresses never alias into the array.
  assign w_idx_full = (BYTE_ADDR != 0) ? (req_addr >> 2) : req_addr;
  assign w_idx      = w_idx_full[IDX_W-1:0];
  assign w_misalign = (BYTE_ADDR != 0) && (req_addr[1:0] != 2'b00);
  assign w_range    = {1'b0, w_idx_full} >= (ADDR_W + 1)'(DEPTH);
  assign w_fault    = w_misalign || w_range;

  assign w_stall    = rsp_valid && !rsp_ready;
  assign req_ready  = !w_stall && !flush;
  assign w_accept   = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd <= '0;
    end else if (flush) begin
      r_rd.valid <= 1'b0;
    end else if (!w_stall) begin
      if (w_accept) begin
        r_rd.valid <= 1'b1;
        r_rd.fault <= w_fault;
        r_rd.instr <= w_fault ? DATA_W'(NOP_INSTR) : r_mem[w_idx];
      end else begin
        r_rd.valid <= 1'b0;
      end
    end
  end

  assign w_stage[0] = r_rd;

  for (genvar s = 1; s < LATENCY; s++) begin : g_stage
    imem_pipe_stage #(
      .payload_t (stage_t)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (!w_stall),
      .i_clr (flush),
      .i_d   (w_stage[s-1]),
      .o_q   (w_stage[s])
    );
  end

  assign rsp_valid = w_stage[LATENCY-1].valid;
  assign rsp_fault = w_stage[LATENCY-1].fault;
  assign rsp_instr = w_stage[LATENCY-1].instr;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: directed scenarios plus random traffic against a queue-based
// reference model of in-flight fetches; extra word-addressed instances cover other latencies.
module tb_instr_fetch_mem;

  localparam int DEP = 1024;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_instr;
  logic        rsp_fault;
  logic        flush = 1'b0;
  logic        prog_we = 1'b0;
  logic [9:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;

  logic        sw_req_valid = 1'b0;
  logic [31:0] sw_req_addr = '0;
  logic        sw_rsp_ready = 1'b1;
  logic        sw_flush = 1'b0;
  logic        sw_req_ready [3];
  logic        sw_rsp_valid [3];
  logic [31:0] sw_rsp_instr [3];
  logic        sw_rsp_fault [3];

  always #5 clk = ~clk;

  instr_fetch_mem #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEP), .BYTE_ADDR(1), .LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_fault(rsp_fault),
    .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sw
    instr_fetch_mem #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(DEP), .BYTE_ADDR(0),
      .LATENCY((g == 0) ? 1 : g + 2), .INIT_FILE("")
    ) u_sw (
      .clk(clk), .rst_n(rst_n),
      .req_valid(sw_req_valid), .req_ready(sw_req_ready[g]), .req_addr(sw_req_addr),
      .rsp_valid(sw_rsp_valid[g]), .rsp_ready(sw_rsp_ready), .rsp_instr(sw_rsp_instr[g]),
      .rsp_fault(sw_rsp_fault[g]),
      .flush(sw_flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );
  end

  typedef struct {
    int          age;
    logic        fault;
    logic [31:0] instr;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] mmem [DEP];
  logic [31:0] last_instr = '0;
  logic        last_fault = 1'b0;
  logic [31:0] got[$];
  logic        gotf[$];
  bit          acc_last;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a);
    exp_t        e;
    logic [31:0] idx;
    idx     = a >> 2;
    e.age   = 0;
    e.fault = (a[1:0] != 2'b00) || (idx >= 32'(DEP));
    e.instr = e.fault ? 32'h0 : mmem[idx[9:0]];
    return e;
  endfunction

  function automatic bit model_valid();
    return (mq.size() > 0) && (mq[0].age >= LAT - 1);
  endfunction

  // One clock: check outputs mid-cycle, advance the model across the coming edge.
  task automatic cycle();
    bit mv;
    bit stall;
    @(negedge clk);
    mv    = model_valid();
    stall = mv && !rsp_ready;
    if (rst_n) chk("req_ready", req_ready, !stall && !flush);
    chk("rsp_valid", rsp_valid, mv);
    if (mv) begin
      last_instr = mq[0].instr;
      last_fault = mq[0].fault;
    end
    chk("rsp_instr", rsp_instr, last_instr);
    chk("rsp_fault", rsp_fault, last_fault);
    if (rsp_valid && rsp_ready) begin
      got.push_back(rsp_instr);
      gotf.push_back(rsp_fault);
    end
    acc_last = 1'b0;
    if (!rst_n || flush) begin
      mq.delete();
    end else if (!stall) begin
      if (mv) void'(mq.pop_front());
      foreach (mq[i]) mq[i].age++;
      if (req_valid) begin
        mq.push_back(mk(req_addr));
        acc_last = 1'b1;
      end
    end
    if (prog_we) mmem[prog_addr] = prog_data;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    for (int t = 0; t < 40; t++) begin
      cycle();
      if (acc_last) break;
    end
    chk("fetch_accept", 32'(acc_last), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    flush     = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic sweep_req(input logic [31:0] a, input logic [31:0] ei, input logic ef);
    int lat [3];
    bit seen [3];
    for (int g = 0; g < 3; g++) begin
      lat[g]  = 0;
      seen[g] = 1'b0;
    end
    sw_req_valid = 1'b1;
    sw_req_addr  = a;
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk("sw_req_ready", sw_req_ready[g], 32'd1);
    @(posedge clk);
    #1;
    sw_req_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (!seen[g] && sw_rsp_valid[g]) begin
          seen[g] = 1'b1;
          lat[g]  = j + 1;
          chk("sw_instr", sw_rsp_instr[g], ei);
          chk("sw_fault", sw_rsp_fault[g], ef);
        end
      end
      @(posedge clk);
      #1;
    end
    for (int g = 0; g < 3; g++) chk("sw_latency", lat[g], (g == 0) ? 1 : g + 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    // Load image i+0x100 through the program port while reset is held.
    for (int i = 0; i < DEP; i++) begin
      prog_we   = 1'b1;
      prog_addr = 10'(i);
      prog_data = 32'h100 + 32'(i);
      cycle();
    end
    prog_we = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();

    got.delete(); gotf.delete();
    for (int k = 0; k < 4; k++) fetch(32'(4 * k));
    drain(4);
    chk("stream_count", got.size(), 32'd4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk("stream_data", got[k], 32'h100 + 32'(k));

    got.delete(); gotf.delete();
    begin
      int idx = 0;
      for (int c = 0; c < 40 && idx < 8; c++) begin
        rsp_ready = !(c >= 4 && c < 7);
        req_valid = 1'b1;
        req_addr  = 32'(4 * idx);
        cycle();
        if (acc_last) idx++;
      end
    end
    drain(6);
    chk("bp_count", got.size(), 32'd8);
    for (int k = 0; k < 8 && k < got.size(); k++) chk("bp_data", got[k], 32'h100 + 32'(k));

    got.delete(); gotf.delete();
    fetch(32'h2); fetch(32'h1000); fetch(32'hFFC); fetch(32'h4);
    drain(4);
    chk("fault_count", got.size(), 32'd4);
    if (got.size() == 4) begin
      chk("fault_misalign_i", got[0], 32'h0);   chk("fault_misalign_f", gotf[0], 32'd1);
      chk("fault_range_i", got[1], 32'h0);      chk("fault_range_f", gotf[1], 32'd1);
      chk("last_word_i", got[2], 32'h4FF);      chk("last_word_f", gotf[2], 32'd0);
      chk("after_fault_i", got[3], 32'h101);    chk("after_fault_f", gotf[3], 32'd0);
    end

    got.delete(); gotf.delete();
    rsp_ready = 1'b0;
    fetch(32'h0); fetch(32'h4);
    req_valid = 1'b1; req_addr = 32'h20; flush = 1'b1;
    cycle();
    req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    cycle();
    fetch(32'h10);
    drain(4);
    chk("flush_count", got.size(), 32'd1);
    if (got.size() == 1) chk("flush_next", got[0], 32'h104);

    got.delete(); gotf.delete();
    prog_we = 1'b1; prog_addr = 10'd2; prog_data = 32'hDEADBEEF;
    fetch(32'h8);
    prog_we = 1'b0;
    fetch(32'h8);
    drain(4);
    chk("coll_count", got.size(), 32'd2);
    if (got.size() == 2) begin
      chk("coll_old", got[0], 32'h102);
      chk("coll_new", got[1], 32'hDEADBEEF);
    end

    got.delete(); gotf.delete();
    fetch(32'h0); fetch(32'h4);
    rst_n = 1'b0;
    mq.delete(); last_instr = '0; last_fault = 1'b0;
    #1;
    chk("async_reset_valid", rsp_valid, 32'd0);
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    fetch(32'h8);
    drain(4);
    chk("reset_drop_count", got.size(), 32'd1);
    if (got.size() == 1) chk("mem_kept", got[0], 32'hDEADBEEF);

    sweep_req(32'd5, 32'h105, 1'b0);
    sweep_req(32'd1024, 32'h0, 1'b1);
    sweep_req(32'd1023, 32'h4FF, 1'b0);

    for (int n = 0; n < 500; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      req_valid = ($urandom_range(0, 3) != 0);
      if (r < 4)       req_addr = 32'($urandom_range(0, 15)) * 4;
      else if (r < 7)  req_addr = 32'($urandom_range(0, DEP - 1)) * 4;
      else if (r == 7) req_addr = (32'($urandom_range(0, 255)) * 4) | 32'($urandom_range(1, 3));
      else if (r == 8) req_addr = 32'(DEP * 4) + 32'($urandom_range(0, 999)) * 4;
      else             req_addr = 32'hFFFF_FFFC;
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      prog_we   = ($urandom_range(0, 7) == 0);
      prog_addr = 10'($urandom_range(0, 15));
      prog_data = $urandom;
      cycle();
    end
    prog_we = 1'b0;
    drain(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
